// File: rtl/i2c_reg_slave.sv
// I2C register-file slave: a 7-bit address, a pointer byte, then bytes that are written
// or read with an auto-incrementing pointer. SDA is open-drain (0 = pull low, 1 = release).
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         NUM_REGS   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       busy_o,
    output logic       wr_stb_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic [3:0] state_o
);

    localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t          state;
    logic [2:0]      scl_sync;
    logic [2:0]      sda_sync;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift;
    logic            rw;
    logic [PW-1:0]   ptr;
    logic [7:0]      regs [NUM_REGS];

    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic [2:0] rd_idx;

    // Bit [1] is the synchronised level, bit [2] its previous value for edge detection.
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_det = scl_sync[1] & sda_sync[2] & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & ~sda_sync[2] & sda_sync[1];
    assign rx_byte   = {shift[6:0], sda_sync[1]};
    assign rd_idx    = 3'd7 - bit_cnt[2:0];
    assign state_o   = state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_i};
            sda_sync <= {sda_sync[1:0], sda_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            sda_o     <= 1'b1;
            busy_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= 8'h00;
            wr_data_o <= 8'h00;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            ptr       <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            wr_stb_o <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_o   <= 1'b1;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_o  <= 1'b1;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift[7:1] == SLAVE_ADDR) begin
                                state  <= ADDR_ACK;
                                sda_o  <= 1'b0;
                                busy_o <= 1'b1;
                                rw     <= shift[0];
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state <= RDATA;
                                shift <= regs[ptr];
                                sda_o <= regs[ptr][7];
                            end else begin
                                state <= PTR;
                                sda_o <= 1'b1;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr   <= shift[PW-1:0];
                            sda_o <= 1'b0;
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_o   <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: begin
                        // The byte is committed on its 8th rising edge, before the ACK slot.
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                regs[ptr] <= rx_byte;
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= 8'(ptr);
                                wr_data_o <= rx_byte;
                                ptr       <= ptr + PW'(1);
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_o <= 1'b0;
                            state <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        // A falling edge at count 0 only occurs after a master ACK; it drives the MSB.
                        if (scl_rise && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) ptr <= ptr + PW'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_o <= 1'b1;
                                state <= RDATA_ACK;
                            end else begin
                                sda_o <= shift[rd_idx];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_sync[1]) begin
                                state   <= RDATA;
                                bit_cnt <= 4'd0;
                                shift   <= regs[ptr];
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: a bit-banged I2C master, a register-file reference model and
// a scoreboard that matches write commits and read bytes against expected queues.
module tb_i2c_reg_slave;

    localparam int Q    = 6;
    localparam int NREG = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic       sda_o, busy_o, wr_stb_o;
    logic [7:0] wr_addr_o, wr_data_o;
    logic [3:0] state_o;

    assign sda_bus = m_sda & sda_o;

    always #5 clk = ~clk;

    i2c_reg_slave #(.SLAVE_ADDR(7'h22), .NUM_REGS(NREG)) dut (
        .clk_i(clk), .rst_i(rst_i), .scl_i(m_scl), .sda_i(sda_bus), .sda_o(sda_o),
        .busy_o(busy_o), .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .state_o(state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  got_rd_q[$];
    logic [7:0]  wbuf[$];
    logic [7:0]  m_regs[NREG];
    int          m_ptr;
    logic [15:0] e_wr;
    logic [7:0]  e_rd, g_rd;
    logic        watch = 1'b0, saw_low = 1'b0, saw_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: commits and read bytes are matched as they appear.
    always @(negedge clk) begin
        if (rst_i === 1'b1 && wr_stb_o === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got %0h/%0h expected no commit", wr_addr_o, wr_data_o);
            end else begin
                e_wr = exp_wr_q.pop_front();
                check("wr_commit", {16'h0, wr_addr_o, wr_data_o}, {16'h0, e_wr});
            end
        end
        if (got_rd_q.size() > 0) begin
            g_rd = got_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected nothing", g_rd);
            end else begin
                e_rd = exp_rd_q.pop_front();
                check("rd_byte", {24'h0, g_rd}, {24'h0, e_rd});
            end
        end
        if (watch) begin
            if (sda_o === 1'b0) saw_low = 1'b1;
            if (busy_o === 1'b1) saw_busy = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(2*Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(2*Q);
    endtask

    task automatic send_bit(input logic b);
        tick(Q); m_sda = b;
        tick(Q); m_scl = 1'b1;
        tick(2*Q); m_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); m_sda = 1'b1;
        tick(Q); m_scl = 1'b1;
        tick(Q); b = sda_bus;
        tick(Q); m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        check(name, {31'h0, a}, {31'h0, exp_ack});
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic x;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(x);
            b = {b[6:0], x};
        end
    endtask

    // Write the bytes queued in wbuf starting at register p.
    task automatic do_write(input int p);
        bus_start();
        send_byte(8'h44, 1'b0, "ack_addr_w");
        send_byte(8'(p), 1'b0, "ack_ptr");
        m_ptr = p % NREG;
        foreach (wbuf[i]) begin
            exp_wr_q.push_back({8'(m_ptr), wbuf[i]});
            m_regs[m_ptr] = wbuf[i];
            m_ptr = (m_ptr + 1) % NREG;
            send_byte(wbuf[i], 1'b0, "ack_wdata");
        end
        check("busy_in_write", {31'h0, busy_o}, 32'd1);
        bus_stop();
        check("busy_after_write", {31'h0, busy_o}, 32'd0);
    endtask

    // Read n bytes, optionally setting the pointer first via a repeated START.
    task automatic do_read(input bit set_ptr, input int p, input int n);
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            send_byte(8'h44, 1'b0, "ack_addr_w");
            send_byte(8'(p), 1'b0, "ack_ptr");
            m_ptr = p % NREG;
            bus_start();
        end
        send_byte(8'h45, 1'b0, "ack_addr_r");
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NREG;
            recv_byte(d);
            got_rd_q.push_back(d);
            send_bit(i == n - 1);
        end
        check("busy_in_read", {31'h0, busy_o}, 32'd1);
        bus_stop();
        check("busy_after_read", {31'h0, busy_o}, 32'd0);
        check("idle_after_read", {28'h0, state_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda"}, {31'h0, sda_o}, 32'd1);
        check({tag, "_busy"}, {31'h0, busy_o}, 32'd0);
        check({tag, "_stb"}, {31'h0, wr_stb_o}, 32'd0);
        check({tag, "_waddr"}, {24'h0, wr_addr_o}, 32'd0);
        check({tag, "_wdata"}, {24'h0, wr_data_o}, 32'd0);
        check({tag, "_state"}, {28'h0, state_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic b;
        int   p, n;
        m_scl = 1'b1;
        m_sda = 1'b1;
        rst_i = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        tick(4);
        check_reset_outputs("reset");
        rst_i = 1'b1;
        tick(4);

        // Write A5, 5A at 3, then combined read of two bytes, then read from current ptr (5).
        wbuf = '{8'hA5, 8'h5A};
        do_write(3);
        do_read(1, 3, 2);
        do_read(0, 0, 1);

        // Pointer wrap on write and read.
        wbuf = '{8'h11, 8'h22};
        do_write(15);
        do_read(1, 15, 2);

        // STOP after 3 bits of a data byte: nothing committed.
        bus_start();
        send_byte(8'h44, 1'b0, "ack_addr_w");
        send_byte(8'h03, 1'b0, "ack_ptr");
        m_ptr = 3;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        check("abort_idle", {28'h0, state_o}, 32'd0);
        do_read(0, 0, 1);

        // Address miss: no ACK, no busy, no drive.
        saw_low = 1'b0; saw_busy = 1'b0; watch = 1'b1;
        bus_start();
        send_byte(8'h46, 1'b1, "nack_miss");
        bus_stop();
        watch = 1'b0;
        check("miss_sda_low", {31'h0, saw_low}, 32'd0);
        check("miss_busy", {31'h0, saw_busy}, 32'd0);

        // Reset in the middle of a read of an all-zero register.
        wbuf = '{8'h00};
        do_write(9);
        bus_start();
        send_byte(8'h44, 1'b0, "ack_addr_w");
        send_byte(8'h09, 1'b0, "ack_ptr");
        bus_start();
        send_byte(8'h45, 1'b0, "ack_addr_r");
        recv_bit(b); recv_bit(b); recv_bit(b);
        tick(Q);
        check("rd_drive_low", {31'h0, sda_o}, 32'd0);
        #1 rst_i = 1'b0;
        #1 check("rst_async_sda", {31'h0, sda_o}, 32'd1);
        tick(2);
        check_reset_outputs("midreset");
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        m_scl = 1'b1; m_sda = 1'b1;
        tick(4);
        rst_i = 1'b1;
        tick(4);

        // Bus activity without START is ignored after reset.
        saw_low = 1'b0; watch = 1'b1;
        m_scl = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(1'(i % 2));
        watch = 1'b0;
        check("ignore_state", {28'h0, state_o}, 32'd0);
        check("ignore_sda_low", {31'h0, saw_low}, 32'd0);
        do_read(0, 0, 1);

        // Randomised writes and reads against the model.
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, NREG - 1);
            n = $urandom_range(1, 3);
            wbuf.delete();
            for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
            do_write(p);
            do_read(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(1, 3));
        end

        tick(10);
        check("wr_q_drained", exp_wr_q.size(), 32'd0);
        check("rd_q_drained", exp_rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
